blit_color_pipe: RTL

Parametrised, handshaked successor to the single-pixel blitter colour stage. Each beat carries PIXELS pixels. Per pixel, the block selects a colour from one of four sources: fill, 1bpp text expansion, memory copy, or destination XOR. It then applies the transparent-colour key and emits packed pixel data with per-pixel write enables. It sits between the blitter source-fetch stage and the framebuffer write port, and replaces the global `stall` with valid/ready back-pressure.

---
 rtl/blit_pkg.sv | 15 +
 rtl/blit_color_lane.sv | 63 ++++++
 rtl/blit_color_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the blitter colour pipeline: mode encodings and
// default geometry.
package blit_pkg;

  localparam int unsigned BLIT_PIXELS_DEF = 4;
  localparam int unsigned BLIT_CW_DEF     = 8;

  typedef enum logic [1:0] {
    BLIT_MODE_FILL = 2'b00,
    BLIT_MODE_TEXT = 2'b01,
    BLIT_MODE_COPY = 2'b10,
    BLIT_MODE_XOR  = 2'b11
  } blit_mode_e;

endpackage

// File: rtl/blit_color_lane.sv
// One pixel lane of the colour pipe: colour source select (feeds S1) and
// transparent-key compare / data gating (feeds S2). Purely combinational.
// Optional feature macro: BLIT_COLOR_XOR_EN (mode 11 = destination XOR,
// otherwise mode 11 behaves as fill).
module blit_color_lane
  import blit_pkg::*;
#(
  parameter int unsigned CW   = BLIT_CW_DEF,
  parameter int unsigned LANE = 0
) (
  input  logic [1:0]    sel_mode_i,
  input  logic [CW-1:0] src_i,
  input  logic [CW-1:0] dst_i,
  input  logic [7:0]    glyph_i,
  input  logic [2:0]    bit_i,
  input  logic [CW:0]   fg_i,
  input  logic [CW:0]   bg_i,
  output logic [CW:0]   color_o,
  input  logic [1:0]    key_mode_i,
  input  logic [CW:0]   key_color_i,
  input  logic          key_mask_i,
  input  logic [CW:0]   transparent_i,
  output logic          en_o,
  output logic [CW-1:0] data_o
);

  localparam logic [2:0] LANE_OFS = 3'(LANE % 8);

  logic [2:0] bit_idx;
  logic       ignore_key;

  // 3-bit add wraps the glyph bit index from 7 back to 0.
  assign bit_idx = bit_i + LANE_OFS;

`ifdef BLIT_COLOR_XOR_EN
  assign ignore_key = (key_mode_i == BLIT_MODE_XOR);
`else
  logic unused_xor;
  assign ignore_key = 1'b0;
  assign unused_xor = ^{dst_i, key_mode_i};
`endif

  // Colour source select for this lane.
  always_comb begin
    color_o = fg_i;
    case (sel_mode_i)
      BLIT_MODE_FILL: color_o = fg_i;
      BLIT_MODE_TEXT: color_o = glyph_i[bit_idx] ? fg_i : bg_i;
      BLIT_MODE_COPY: color_o = {1'b0, src_i};
`ifdef BLIT_COLOR_XOR_EN
      BLIT_MODE_XOR:  color_o = {1'b0, dst_i ^ fg_i[CW-1:0]};
`endif
      default:        color_o = fg_i;
    endcase
  end

  // Transparent-key compare and zeroing of disabled lanes.
  always_comb begin
    en_o   = key_mask_i && (ignore_key || (key_color_i != transparent_i));
    data_o = en_o ? key_color_i[CW-1:0] : '0;
  end

endmodule

// File: rtl/blit_color_pipe.sv
// Two-stage handshaked blitter colour pipe. S1 registers per-lane colours,
// S2 registers keyed/gated pixel data with write enables.
// Optional feature macro: BLIT_COLOR_XOR_EN (see blit_color_lane).
module blit_color_pipe
  import blit_pkg::*;
#(
  parameter int unsigned PIXELS = BLIT_PIXELS_DEF,
  parameter int unsigned CW     = BLIT_CW_DEF,
  parameter int unsigned AW     = 26
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [PIXELS*CW-1:0] in_src_data,
  input  logic [7:0]           in_src_byte,
  input  logic [2:0]           in_src_bit,
  input  logic [PIXELS*CW-1:0] in_dst_data,
  input  logic [PIXELS-1:0]    in_mask,
  input  logic [AW-1:0]        in_addr,
  input  logic [CW:0]          fg_color,
  input  logic [CW:0]          bg_color,
  input  logic [CW:0]          transparent_color,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIXELS*CW-1:0] out_data,
  output logic [PIXELS-1:0]    out_enable,
  output logic [AW-1:0]        out_addr,
  output logic [31:0]          beat_count
);

  logic                      s1_valid_q, s1_valid_d;
  logic [PIXELS-1:0][CW:0]   s1_color_q, s1_color_d;
  logic [PIXELS-1:0]         s1_mask_q,  s1_mask_d;
  logic [AW-1:0]             s1_addr_q,  s1_addr_d;
  logic [1:0]                s1_mode_q,  s1_mode_d;

  logic                      out_valid_q,  out_valid_d;
  logic [PIXELS*CW-1:0]      out_data_q,   out_data_d;
  logic [PIXELS-1:0]         out_enable_q, out_enable_d;
  logic [AW-1:0]             out_addr_q,   out_addr_d;
  logic [31:0]               beat_count_q, beat_count_d;

  logic [PIXELS-1:0][CW:0]   lane_color;
  logic [PIXELS-1:0]         lane_en;
  logic [PIXELS-1:0][CW-1:0] lane_data;

  logic s2_load;
  logic s1_load;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  for (genvar i = 0; i < int'(PIXELS); i++) begin : g_lane
    blit_color_lane #(
      .CW   (CW),
      .LANE (i)
    ) u_lane (
      .sel_mode_i    (in_mode),
      .src_i         (in_src_data[i*CW +: CW]),
      .dst_i         (in_dst_data[i*CW +: CW]),
      .glyph_i       (in_src_byte),
      .bit_i         (in_src_bit),
      .fg_i          (fg_color),
      .bg_i          (bg_color),
      .color_o       (lane_color[i]),
      .key_mode_i    (s1_mode_q),
      .key_color_i   (s1_color_q[i]),
      .key_mask_i    (s1_mask_q[i]),
      .transparent_i (transparent_color),
      .en_o          (lane_en[i]),
      .data_o        (lane_data[i])
    );
  end

  // Next-state for both pipeline stages and the beat counter.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_color_d   = s1_color_q;
    s1_mask_d    = s1_mask_q;
    s1_addr_d    = s1_addr_q;
    s1_mode_d    = s1_mode_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_enable_d = out_enable_q;
    out_addr_d   = out_addr_q;
    beat_count_d = beat_count_q + 32'(out_valid_q && out_ready);

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_color_d = lane_color;
        s1_mask_d  = in_mask;
        s1_addr_d  = in_addr;
        s1_mode_d  = in_mode;
      end
    end

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = lane_data;
        out_enable_d = lane_en;
        out_addr_d   = s1_addr_q;
      end
    end
  end

  // Pipeline and counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_color_q   <= '0;
      s1_mask_q    <= '0;
      s1_addr_q    <= '0;
      s1_mode_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_enable_q <= '0;
      out_addr_q   <= '0;
      beat_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_color_q   <= s1_color_d;
      s1_mask_q    <= s1_mask_d;
      s1_addr_q    <= s1_addr_d;
      s1_mode_q    <= s1_mode_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_enable_q <= out_enable_d;
      out_addr_q   <= out_addr_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_enable = out_enable_q;
  assign out_addr   = out_addr_q;
  assign beat_count = beat_count_q;

endmodule
